udp_tx_arbiter: RTL and testbench

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single UDP transmit engine.
// A granted requester gets one ready pulse, its frame is started on the engine,
// its data/word-request handshake is routed through, and it gets a done pulse.
// A fixed idle gap follows every frame. A SEND-phase watchdog frees the engine
// if udp_tx_done never arrives.
module udp_tx_arbiter #(
    parameter int GAP_CYCLES = 12,
    parameter int TIMEOUT    = 65535
) (
    input  logic        gmii_rx_clk,
    input  logic        rstn,

    input  logic        req0_valid,
    input  logic [15:0] req0_byte_num,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    output logic        req0_tx_req,
    output logic        req0_done,

    input  logic        req1_valid,
    input  logic [15:0] req1_byte_num,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        req1_tx_req,
    output logic        req1_done,

    output logic        udp_tx_start,
    output logic [15:0] udp_tx_byte_num,
    output logic [31:0] udp_tx_data,
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,

    output logic [1:0]  arb_grant,
    output logic        arb_busy,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Terminal counts, computed once at elaboration.
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [15:0] GAP_LAST    = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;

    logic        grant_idx;   // index of the requester that owns the current frame
    logic        last_ptr;    // index of the last requester that completed a frame
    logic [15:0] len_q;       // latched byte count of the current frame
    logic        zlen_pend;   // zero-length frame still owes its done pulse
    logic [15:0] send_cnt;    // cycles spent in SEND for the current frame
    logic [15:0] gap_cnt;     // cycles spent in GAP for the current gap

    logic [1:0]  ready_q;
    logic [1:0]  done_q;

    logic        any_valid;
    logic        winner;
    logic [15:0] win_len;
    logic        send_term;
    logic        gap_end;

    logic        accept;
    logic        fire_start;
    logic        fire_done;
    logic        fire_tmo;

    // Round-robin selection: contention goes to the requester not served last;
    // a lone request always wins.
    assign any_valid = req0_valid | req1_valid;
    assign winner    = (req0_valid & req1_valid) ? ~last_ptr : req1_valid;
    assign win_len   = winner ? req1_byte_num : req0_byte_num;
    assign send_term = (send_cnt == TIMEOUT_CNT);
    assign gap_end   = (gap_cnt >= GAP_LAST);

    // State register.
    always_ff @(posedge gmii_rx_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state logic and single-cycle event strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would infer a latch.
        state_nxt  = state;
        accept     = 1'b0;
        fire_start = 1'b0;
        fire_done  = 1'b0;
        fire_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept    = 1'b1;
                    state_nxt = (win_len == 16'd0) ? GAP : START;
                end
            end
            START: begin
                fire_start = 1'b1;
                state_nxt  = SEND;
            end
            SEND: begin
                // done has priority over the watchdog on the terminal count
                if (udp_tx_done) begin
                    fire_done = 1'b1;
                    state_nxt = GAP;
                end else if (send_term) begin
                    fire_tmo  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                fire_done = zlen_pend;
                if (gap_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered one-cycle pulses towards requesters and the engine.
    always_ff @(posedge gmii_rx_clk or negedge rstn) begin
        if (!rstn) begin
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            udp_tx_start <= 1'b0;
            arb_timeout  <= 1'b0;
        end else begin
            ready_q      <= accept    ? {winner, ~winner}       : 2'b00;
            done_q       <= fire_done ? {grant_idx, ~grant_idx} : 2'b00;
            udp_tx_start <= fire_start;
            arb_timeout  <= fire_tmo;
        end
    end

    // Frame bookkeeping: owner, length, counters and round-robin pointer.
    always_ff @(posedge gmii_rx_clk or negedge rstn) begin
        if (!rstn) begin
            grant_idx <= 1'b0;
            last_ptr  <= 1'b1;
            len_q     <= 16'd0;
            zlen_pend <= 1'b0;
            send_cnt  <= 16'd0;
            gap_cnt   <= 16'd0;
        end else begin
            if (accept) begin
                grant_idx <= winner;
                len_q     <= win_len;
                zlen_pend <= (win_len == 16'd0);
            end else if (state == GAP) begin
                zlen_pend <= 1'b0;
            end

            if (fire_start) begin
                send_cnt <= 16'd0;
            end else if (state == SEND) begin
                send_cnt <= send_cnt + 16'd1;
            end

            if (state_nxt == GAP && state != GAP) begin
                gap_cnt <= 16'd0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
            end

            if (state == GAP && gap_end) begin
                last_ptr <= grant_idx;
            end
        end
    end

    // Ownership is visible from START through SEND only; routing follows it.
    assign arb_grant       = (state == START || state == SEND) ? {grant_idx, ~grant_idx} : 2'b00;
    assign arb_busy        = (state != IDLE);
    assign udp_tx_byte_num = len_q;
    assign req0_tx_req     = arb_grant[0] & udp_tx_req;
    assign req1_tx_req     = arb_grant[1] & udp_tx_req;
    assign udp_tx_data     = arb_grant[0] ? req0_data :
                             arb_grant[1] ? req1_data : 32'd0;
    assign req0_ready      = ready_q[0];
    assign req1_ready      = ready_q[1];
    assign req0_done       = done_q[0];
    assign req1_done       = done_q[1];

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter. Expected behaviour is derived per frame
// from the arbitration rules (who wins, when ready/start/done/timeout appear,
// how long the gap lasts) and compared every cycle against the outputs.
module tb_udp_tx_arbiter;

    localparam int GAP = 12;
    localparam int TMO = 100;

    logic        gmii_rx_clk;
    logic        rstn;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_byte_num, req1_byte_num;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        req0_tx_req, req1_tx_req;
    logic        req0_done, req1_done;
    logic        udp_tx_start;
    logic [15:0] udp_tx_byte_num;
    logic [31:0] udp_tx_data;
    logic        udp_tx_req;
    logic        udp_tx_done;
    logic [1:0]  arb_grant;
    logic        arb_busy;
    logic        arb_timeout;

    int n_chk = 0;
    int n_bad = 0;
    int last_served = 1;   // reference round-robin memory

    udp_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .gmii_rx_clk     (gmii_rx_clk),
        .rstn            (rstn),
        .req0_valid      (req0_valid),
        .req0_byte_num   (req0_byte_num),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req0_tx_req     (req0_tx_req),
        .req0_done       (req0_done),
        .req1_valid      (req1_valid),
        .req1_byte_num   (req1_byte_num),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .req1_tx_req     (req1_tx_req),
        .req1_done       (req1_done),
        .udp_tx_start    (udp_tx_start),
        .udp_tx_byte_num (udp_tx_byte_num),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_done     (udp_tx_done),
        .arb_grant       (arb_grant),
        .arb_busy        (arb_busy),
        .arb_timeout     (arb_timeout)
    );

    initial gmii_rx_clk = 1'b0;
    always #5 gmii_rx_clk = ~gmii_rx_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to a point safely after the rising edge.
    task automatic step();
        @(posedge gmii_rx_clk);
        #2;
    endtask

    // Random traffic on inputs whose value must not matter in the current state.
    task automatic drive_noise(input bit with_done);
        udp_tx_req = 1'($urandom_range(0, 1));
        req0_data  = $urandom;
        req1_data  = $urandom;
        if (with_done) udp_tx_done = 1'($urandom_range(0, 1));
    endtask

    // Compare all status/pulse outputs and the grant-dependent routing.
    task automatic expect_cycle(input string ph, input logic [1:0] rdy, input logic [1:0] dn,
                                input logic [1:0] gr, input logic st, input logic bz,
                                input logic to);
        logic [1:0]  exp_txr;
        logic [31:0] exp_data;
        exp_txr  = (gr == 2'b01) ? {1'b0, udp_tx_req} :
                   (gr == 2'b10) ? {udp_tx_req, 1'b0} : 2'b00;
        exp_data = (gr == 2'b01) ? req0_data : (gr == 2'b10) ? req1_data : 32'd0;
        check({ph, ".ready"},   32'({req1_ready, req0_ready}),   32'(rdy));
        check({ph, ".done"},    32'({req1_done, req0_done}),     32'(dn));
        check({ph, ".grant"},   32'(arb_grant),                  32'(gr));
        check({ph, ".start"},   32'(udp_tx_start),               32'(st));
        check({ph, ".busy"},    32'(arb_busy),                   32'(bz));
        check({ph, ".timeout"}, 32'(arb_timeout),                32'(to));
        check({ph, ".tx_req"},  32'({req1_tx_req, req0_tx_req}), 32'(exp_txr));
        check({ph, ".data"},    udp_tx_data,                     exp_data);
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_noise(1);
            step();
            expect_cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One frame from acceptance to the following IDLE cycle. Called in an IDLE
    // cycle. done_at: SEND cycle index carrying udp_tx_done, -1 for never.
    // blip: the other requester raises valid briefly during the gap and drops it.
    task automatic run_frame(input bit v0, input bit v1, input logic [15:0] b0,
                             input logic [15:0] b1, input int done_at, input bit blip);
        int          w;
        int          gap_used;
        logic [1:0]  one;
        logic [15:0] bn;
        req0_valid    = v0;
        req1_valid    = v1;
        req0_byte_num = b0;
        req1_byte_num = b1;
        w   = (v0 && v1) ? ((last_served == 1) ? 0 : 1) : (v1 ? 1 : 0);
        one = (w == 1) ? 2'b10 : 2'b01;
        bn  = (w == 1) ? b1 : b0;
        drive_noise(1);
        step();
        if (bn == 16'd0) begin
            expect_cycle("zl_accept", one, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
            drive_noise(1);
            step();
            expect_cycle("zl_done", 2'b00, one, 2'b00, 1'b0, 1'b1, 1'b0);
            gap_used = 2;
        end else begin
            expect_cycle("accept", one, 2'b00, one, 1'b0, 1'b1, 1'b0);
            if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
            drive_noise(1);
            for (int k = 0; k <= TMO; k++) begin
                step();
                expect_cycle("send", 2'b00, 2'b00, one, (k == 0), 1'b1, 1'b0);
                check("send.byte_num", 32'(udp_tx_byte_num), 32'(bn));
                drive_noise(0);
                udp_tx_done = (k == done_at);
                if (k == done_at) break;
            end
            step();
            if (done_at >= 0)
                expect_cycle("end_done", 2'b00, one, 2'b00, 1'b0, 1'b1, 1'b0);
            else
                expect_cycle("end_timeout", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
            gap_used = 1;
        end
        for (int g = gap_used; g < GAP; g++) begin
            if (blip) begin
                if (w == 1) req0_valid = (g >= 3 && g < 6);
                else        req1_valid = (g >= 3 && g < 6);
            end
            drive_noise(1);
            step();
            expect_cycle("gap", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        end
        drive_noise(1);
        step();
        expect_cycle("back_idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        last_served = w;
    endtask

    // Abort a frame in SEND with reset and confirm a clean restart.
    task automatic reset_mid_send();
        req0_valid    = 1'b1;
        req1_valid    = 1'b0;
        req0_byte_num = 16'd64;
        drive_noise(0);
        udp_tx_done = 1'b0;
        step();
        expect_cycle("rst_accept", 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        repeat (3) step();
        expect_cycle("rst_send", 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        udp_tx_req = 1'b1;
        rstn       = 1'b0;
        #1;
        expect_cycle("rst_async", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("rst_async.byte_num", 32'(udp_tx_byte_num), 32'd0);
        udp_tx_done = 1'b1;
        repeat (2) begin
            step();
            expect_cycle("rst_hold", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        rstn = 1'b1;
        last_served = 1;
        idle_cycles(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        int         d;
        rstn          = 1'b0;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        req0_byte_num = 16'd0;
        req1_byte_num = 16'd0;
        req0_data     = 32'd0;
        req1_data     = 32'd0;
        udp_tx_req    = 1'b0;
        udp_tx_done   = 1'b0;
        repeat (3) step();
        expect_cycle("reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reset.byte_num", 32'(udp_tx_byte_num), 32'd0);
        rstn = 1'b1;
        idle_cycles(2);

        // single request, length 8
        run_frame(1'b1, 1'b0, 16'd8, 16'd0, 5, 1'b0);
        // continuous contention: expect alternation starting from req1 (req0 served last)
        repeat (4) run_frame(1'b1, 1'b1, 16'($urandom_range(1, 64)), 16'($urandom_range(1, 64)),
                             int'($urandom_range(0, 10)), 1'b0);
        // zero-length frame from req1
        run_frame(1'b0, 1'b1, 16'd0, 16'd0, 3, 1'b0);
        // watchdog expiry, then a normal frame
        run_frame(1'b1, 1'b0, 16'd20, 16'd0, -1, 1'b0);
        run_frame(1'b0, 1'b1, 16'd0, 16'd30, 2, 1'b0);
        // done on the terminal count
        run_frame(1'b1, 1'b1, 16'd40, 16'd50, TMO, 1'b0);
        // a request that drops before it is accepted
        run_frame(1'b1, 1'b0, 16'd5, 16'd0, 3, 1'b1);
        idle_cycles(4);
        // reset in SEND, then both valid: req0 must win again
        reset_mid_send();
        run_frame(1'b1, 1'b1, 16'd12, 16'd13, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            v = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 7))
                0:       d = -1;
                1:       d = TMO;
                default: d = int'($urandom_range(0, 30));
            endcase
            run_frame(v[0], v[1],
                      ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 1500)),
                      ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 1500)),
                      d, 1'($urandom_range(0, 1)) & ~(v[0] & v[1]));
        end
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
